// File: rtl/dmem_handshake_responder.sv
// Data-memory responder: one request at a time, response after LATENCY edges.
// Optional byte strobes on stores when DMEM_BYTE_STROBE_EN is defined.
module dmem_handshake_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [3:0]  req_wstrb,
`endif
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   logic [31:0]   mem_q [DEPTH];
   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          accept;
   logic          addr_err;
   logic [AW-1:0] idx;
   logic [31:0]   wr_word;

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

   assign accept   = req_valid & req_ready;
   assign idx      = req_addr[AW+1:2];
   assign addr_err = (req_addr[1:0] != 2'b00)
                   | ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

   // Disabled byte lanes keep the stored value.
   always_comb begin
      wr_word = req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
      for (int i = 0; i < 4; i++) begin
         if (!req_wstrb[i]) begin
            wr_word[8*i +: 8] = mem_q[idx][8*i +: 8];
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (accept && req_write && !addr_err) begin
         mem_q[idx] <= wr_word;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               err_d   = addr_err;
               rdata_d = (!req_write && !addr_err) ? mem_q[idx] : 32'h0;
               if (LAT_M1 == 4'd0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_dmem_handshake_responder.sv
// Directed bench for dmem_handshake_responder (LATENCY=2 and LATENCY=1).
// Strobe cases run when DMEM_BYTE_STROBE_EN is defined.
module tb_dmem_handshake_responder;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        a_req_valid, a_req_write, a_rsp_ready;
   logic [31:0] a_req_addr, a_req_wdata;
   logic [3:0]  a_wstrb;
   logic        a_req_ready, a_rsp_valid, a_rsp_err;
   logic [31:0] a_rsp_rdata;

   logic        b_req_valid, b_req_write, b_rsp_ready;
   logic [31:0] b_req_addr, b_req_wdata;
   logic [3:0]  b_wstrb;
   logic        b_req_ready, b_rsp_valid, b_rsp_err;
   logic [31:0] b_rsp_rdata;

   dmem_handshake_responder #(.DEPTH(64), .LATENCY(2)) u_a (
      .clk       (clk),
      .reset     (reset),
      .req_valid (a_req_valid),
      .req_ready (a_req_ready),
      .req_write (a_req_write),
      .req_addr  (a_req_addr),
      .req_wdata (a_req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
      .req_wstrb (a_wstrb),
`endif
      .rsp_valid (a_rsp_valid),
      .rsp_ready (a_rsp_ready),
      .rsp_rdata (a_rsp_rdata),
      .rsp_err   (a_rsp_err)
   );

   dmem_handshake_responder #(.DEPTH(64), .LATENCY(1)) u_b (
      .clk       (clk),
      .reset     (reset),
      .req_valid (b_req_valid),
      .req_ready (b_req_ready),
      .req_write (b_req_write),
      .req_addr  (b_req_addr),
      .req_wdata (b_req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
      .req_wstrb (b_wstrb),
`endif
      .rsp_valid (b_rsp_valid),
      .rsp_ready (b_rsp_ready),
      .rsp_rdata (b_rsp_rdata),
      .rsp_err   (b_rsp_err)
   );

   int cyc = 0;
   int b_acc[$];
   always @(posedge clk) begin
      cyc++;
      if (b_req_valid && b_req_ready) b_acc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic a_txn(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        output logic [31:0] rd, output logic er);
      int n;
      n = 0;
      while (!a_req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      a_req_valid = 1'b1;
      a_req_write = wr;
      a_req_addr  = addr;
      a_req_wdata = wd;
      a_wstrb     = strb;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      a_req_addr  = 32'h0;
      n = 1;
      while (!a_rsp_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", n, 32'd2);
      rd = a_rsp_rdata;
      er = a_rsp_err;
      a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
      chk("rsp_drop", a_rsp_valid, 32'd0);
      chk("ready_back", a_req_ready, 32'd1);
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      a_req_valid = 0; a_req_write = 0; a_rsp_ready = 0;
      a_req_addr = 0; a_req_wdata = 0; a_wstrb = 4'hF;
      b_req_valid = 0; b_req_write = 0; b_rsp_ready = 1;
      b_req_addr = 0; b_req_wdata = 0; b_wstrb = 4'hF;

      #12;
      chk("rst_req_ready", a_req_ready, 32'd1);
      chk("rst_rsp_valid", a_rsp_valid, 32'd0);
      chk("rst_rdata", a_rsp_rdata, 32'd0);
      chk("rst_err", a_rsp_err, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // reset while waiting
      a_req_valid = 1; a_req_write = 0; a_req_addr = 32'h10;
      @(posedge clk); #1;
      a_req_valid = 0;
      chk("wait_not_ready", a_req_ready, 32'd0);
      reset = 1'b1;
      #1;
      chk("async_rsp_valid", a_rsp_valid, 32'd0);
      chk("async_req_ready", a_req_ready, 32'd1);
      @(posedge clk); #1;
      chk("dropped_rsp", a_rsp_valid, 32'd0);
      reset = 1'b0;

      a_txn(1'b1, 32'h6C, 32'hABCDE7D5, 4'hF, rd, er);
      chk("st6c_err", er, 32'd0);
      chk("st6c_rdata", rd, 32'd0);
      a_txn(1'b0, 32'h6C, 32'h0, 4'hF, rd, er);
      chk("ld6c_rdata", rd, 32'hABCDE7D5);
      chk("ld6c_err", er, 32'd0);

      // backpressure, with req_valid held during RESP
      a_req_valid = 1; a_req_write = 0; a_req_addr = 32'h6C;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("bp_rsp_up", a_rsp_valid, 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", a_rsp_valid, 32'd1);
         chk("bp_rdata", a_rsp_rdata, 32'hABCDE7D5);
         chk("bp_req_ready", a_req_ready, 32'd0);
         @(posedge clk); #1;
      end
      a_rsp_ready = 1;
      @(posedge clk); #1;
      chk("bp_done_valid", a_rsp_valid, 32'd0);
      chk("bp_done_ready", a_req_ready, 32'd1);
      a_rsp_ready = 0;
      a_req_valid = 0;
      @(posedge clk); #1;
      chk("bp_no_accept", a_req_ready, 32'd1);

      // errors and boundaries
      a_txn(1'b1, 32'h0, 32'h12345678, 4'hF, rd, er);
      chk("st0_err", er, 32'd0);
      a_txn(1'b0, 32'h61, 32'h0, 4'hF, rd, er);
      chk("mis_err", er, 32'd1);
      chk("mis_rdata", rd, 32'd0);
      a_txn(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd, er);
      chk("oor_err", er, 32'd1);
      chk("oor_rdata", rd, 32'd0);
      a_txn(1'b0, 32'h0, 32'h0, 4'hF, rd, er);
      chk("w0_intact", rd, 32'h12345678);
      chk("w0_err", er, 32'd0);
      a_txn(1'b1, 32'hFC, 32'h0F0F0F0F, 4'hF, rd, er);
      chk("stfc_err", er, 32'd0);
      a_txn(1'b0, 32'hFC, 32'h0, 4'hF, rd, er);
      chk("ldfc_rdata", rd, 32'h0F0F0F0F);

`ifdef DMEM_BYTE_STROBE_EN
      a_txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er);
      a_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er);
      chk("strb_err", er, 32'd0);
      a_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er);
      chk("strb_merge", rd, 32'h11BB33DD);
      a_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er);
      chk("strb0_err", er, 32'd0);
      a_txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er);
      chk("strb0_noop", rd, 32'h11BB33DD);
`endif

      // LATENCY=1, rsp_ready tied high
      b_req_valid = 1; b_req_write = 1;
      b_req_addr = 32'h8; b_req_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      chk("b_st_valid", b_rsp_valid, 32'd1);
      chk("b_st_err", b_rsp_err, 32'd0);
      chk("b_busy", b_req_ready, 32'd0);
      b_req_write = 0;
      @(posedge clk); #1;
      chk("b_idle_valid", b_rsp_valid, 32'd0);
      chk("b_idle_ready", b_req_ready, 32'd1);
      @(posedge clk); #1;
      chk("b_ld_valid", b_rsp_valid, 32'd1);
      chk("b_ld_rdata", b_rsp_rdata, 32'hCAFEF00D);
      b_req_valid = 0;
      @(posedge clk); #1;
      chk("b_end_valid", b_rsp_valid, 32'd0);
      chk("b_accepts", b_acc.size(), 32'd2);
      if (b_acc.size() == 2) chk("b_gap", b_acc[1] - b_acc[0], 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
